// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of independent 50% duty clock dividers with shadowed half-period loads
module clock_divider_bank #(
  parameter int N_CH     = 4,
  parameter int DIV_W    = 25,
  parameter int DEF_HALF = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  enable,
  input  logic             sync,
  input  logic             load_en,
  input  logic [3:0]       load_sel,
  input  logic [DIV_W-1:0] load_half,
  output logic [N_CH-1:0]  clock_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [DIV_W-1:0] active_half;
    logic [DIV_W-1:0] shadow_half;
    logic [DIV_W-1:0] cnt;
    logic             shadow_valid;
    logic             out_q;
    logic             tick_q;

    logic             run;
    logic             boundary;
    logic             load_hit;
    logic             restart;
    logic             apply;
    logic             next_out;

    always_comb begin
      run      = enable[ch] && (active_half != '0);
      boundary = run && (cnt == active_half - DIV_W'(1));
      load_hit = load_en && (load_sel == 4'(ch));
      // sync, idle and a natural boundary all start a fresh phase, so a pending
      // shadow can be taken over at any of them without shortening a phase.
      restart  = sync || !run || boundary;
      apply    = shadow_valid && restart;
      next_out = out_q;
      if (sync || !run) begin
        next_out = 1'b0;
      end else if (boundary) begin
        next_out = ~out_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        active_half  <= DIV_W'(DEF_HALF);
        shadow_half  <= '0;
        shadow_valid <= 1'b0;
        cnt          <= '0;
        out_q        <= 1'b0;
        tick_q       <= 1'b0;
      end else begin
        out_q  <= next_out;
        tick_q <= next_out & ~out_q;
        if (restart) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
        if (apply) begin
          active_half <= shadow_half;
        end
        // A load in the same cycle as an apply re-arms the shadow with the new value.
        if (load_hit) begin
          shadow_half  <= load_half;
          shadow_valid <= 1'b1;
        end else if (apply) begin
          shadow_valid <= 1'b0;
        end
      end
    end

    assign clock_out[ch] = out_q;
    assign tick[ch]      = tick_q;
    assign pending[ch]   = shadow_valid;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - randomized and directed bench for clock_divider_bank against a cycle model
module tb_clock_divider_bank;
  localparam int N_CH     = 4;
  localparam int DIV_W    = 25;
  localparam int DEF_HALF = 25;
  localparam int MAX_HALF = (1 << DIV_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  enable;
  logic             sync;
  logic             load_en;
  logic [3:0]       load_sel;
  logic [DIV_W-1:0] load_half;
  logic [N_CH-1:0]  clock_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pending;

  clock_divider_bank #(.N_CH(N_CH), .DIV_W(DIV_W), .DEF_HALF(DEF_HALF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync(sync), .load_en(load_en),
    .load_sel(load_sel), .load_half(load_half), .clock_out(clock_out),
    .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: per channel, the half in force, a pending half, and cycles elapsed in the current phase.
  int m_half[N_CH];
  int m_next_half[N_CH];
  bit m_has_next[N_CH];
  int m_elapsed[N_CH];
  bit m_level[N_CH];
  bit m_rose[N_CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int ch = 0; ch < N_CH; ch++) begin
      bit was_level;
      bit phase_over;
      was_level = m_level[ch];
      if (rst) begin
        m_half[ch] = DEF_HALF; m_next_half[ch] = 0; m_has_next[ch] = 0;
        m_elapsed[ch] = 0; m_level[ch] = 0; m_rose[ch] = 0;
        continue;
      end
      phase_over = 0;
      if (sync || !enable[ch] || m_half[ch] == 0) begin
        m_level[ch] = 0;
        phase_over = 1;
      end else if (m_elapsed[ch] + 1 >= m_half[ch]) begin
        m_level[ch] = !m_level[ch];
        phase_over = 1;
      end
      if (phase_over) begin
        m_elapsed[ch] = 0;
        if (m_has_next[ch]) begin
          m_half[ch] = m_next_half[ch];
          m_has_next[ch] = 0;
        end
      end else begin
        m_elapsed[ch] = m_elapsed[ch] + 1;
      end
      if (load_en && int'(load_sel) == ch) begin
        m_next_half[ch] = int'(load_half);
        m_has_next[ch] = 1;
      end
      m_rose[ch] = m_level[ch] && !was_level;
    end
  endtask

  task automatic cycle();
    logic [N_CH-1:0] e_out, e_tick, e_pend;
    @(posedge clk);
    model_step();
    #1;
    for (int ch = 0; ch < N_CH; ch++) begin
      e_out[ch] = m_level[ch];
      e_tick[ch] = m_rose[ch];
      e_pend[ch] = m_has_next[ch];
    end
    check_eq("clock_out", 32'(clock_out), 32'(e_out));
    check_eq("tick", 32'(tick), 32'(e_tick));
    check_eq("pending", 32'(pending), 32'(e_pend));
  endtask

  task automatic load(input int sel, input int half);
    load_en = 1'b1; load_sel = 4'(sel); load_half = DIV_W'(half);
    cycle();
    load_en = 1'b0;
  endtask

  task automatic wait_change(input int ch, input int budget, output int n);
    logic v;
    v = clock_out[ch];
    n = 0;
    while (clock_out[ch] == v && n < budget) begin
      cycle();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; enable = '0; sync = 1'b0; load_en = 1'b0; load_sel = '0; load_half = '0;
    cycle();
    rst = 1'b0;
    check_eq("reset_out", 32'(clock_out), 32'h0);
    check_eq("reset_pending", 32'(pending), 32'h0);
    check_eq("reset_tick", 32'(tick), 32'h0);

    // Default half: first rise 25 cycles after enable, then period 50
    enable = 4'b0001;
    wait_change(0, 200, n); check_eq("def_first_rise", n, 25);
    check_eq("def_tick", 32'(tick), 32'h1);
    wait_change(0, 200, n); check_eq("def_high", n, 25);
    wait_change(0, 200, n); check_eq("def_low", n, 25);
    check_eq("def_others", 32'(clock_out[3:1]), 32'h0);

    // Reload mid-period on a running channel
    enable = 4'b0000;
    cycle();
    load(1, 5);
    cycle();
    enable = 4'b0010;
    wait_change(1, 50, n); check_eq("ch1_rise5", n, 5);
    cycle(); cycle();
    load(1, 3);
    check_eq("ch1_pending", 32'(pending[1]), 32'h1);
    wait_change(1, 50, n); check_eq("ch1_finish5", n, 2);
    check_eq("ch1_pending_clr", 32'(pending[1]), 32'h0);
    wait_change(1, 50, n); check_eq("ch1_phase3a", n, 3);
    wait_change(1, 50, n); check_eq("ch1_phase3b", n, 3);

    // Half 0 stops a channel; half 1 gives clk/2
    enable = 4'b0000;
    cycle();
    load(2, 0);
    cycle();
    enable = 4'b0100;
    repeat (20) cycle();
    check_eq("ch2_stopped", 32'(clock_out[2]), 32'h0);
    load(2, 1);
    wait_change(2, 20, n); check_eq("ch2_start", n, 2);
    wait_change(2, 20, n); check_eq("ch2_div2a", n, 1);
    wait_change(2, 20, n); check_eq("ch2_div2b", n, 1);

    // Sync phase-aligns channels 0 and 3
    enable = 4'b0000;
    cycle();
    load(0, 4);
    load(3, 4);
    cycle();
    enable = 4'b0001;
    repeat (3) cycle();
    enable = 4'b1001;
    repeat (10) cycle();
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    check_eq("sync_zero", 32'({clock_out[3], clock_out[0]}), 32'h0);
    wait_change(0, 20, n); check_eq("sync_rise", n, 4);
    check_eq("sync_ch3_rise", 32'(clock_out[3]), 32'h1);
    for (int i = 0; i < 40; i++) begin
      cycle();
      check_eq("sync_lock", 32'(tick[3]), 32'(tick[0]));
    end

    // Disable while high, then re-enable
    n = 0;
    while (clock_out[0] == 1'b0 && n < 20) begin cycle(); n++; end
    check_eq("ch0_high", 32'(clock_out[0]), 32'h1);
    enable = 4'b1000;
    cycle();
    check_eq("ch0_dropped", 32'(clock_out[0]), 32'h0);
    cycle();
    enable = 4'b1001;
    wait_change(0, 20, n); check_eq("ch0_reenable", n, 4);

    // Reset beats pending loads and sync
    do_reset();
    enable = 4'b1111;
    cycle();
    for (int ch = 0; ch < N_CH; ch++) load(ch, 7);
    check_eq("all_pending", 32'(pending), 32'hF);
    rst = 1'b1; sync = 1'b1; load_en = 1'b1; load_sel = 4'd2; load_half = DIV_W'(3);
    cycle();
    rst = 1'b0; sync = 1'b0; load_en = 1'b0;
    check_eq("rst_out", 32'(clock_out), 32'h0);
    check_eq("rst_pending", 32'(pending), 32'h0);
    wait_change(0, 200, n); check_eq("rst_def_half", n, 25);

    // Out-of-range select is ignored; maximum half is accepted
    load(9, 3);
    check_eq("sel_ignored", 32'(pending), 32'h0);
    load(1, MAX_HALF);
    check_eq("max_pending", 32'(pending[1]), 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) enable[$urandom_range(0, N_CH - 1)] ^= 1'b1;
      sync = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 299) == 0);
      load_en = ($urandom_range(0, 5) == 0);
      load_sel = 4'($urandom_range(0, 5));
      case ($urandom_range(0, 5))
        0: load_half = '0;
        1: load_half = DIV_W'(1);
        2: load_half = DIV_W'(2);
        3: load_half = DIV_W'($urandom_range(3, 9));
        4: load_half = DIV_W'($urandom_range(10, 30));
        default: load_half = DIV_W'(MAX_HALF);
      endcase
      cycle();
    end
    rst = 1'b0; sync = 1'b0; load_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
